// File: rtl/uc_pkg.sv
// Shared constants and helpers for the unit-clause broadcast queue.
// Literal width follows the unit-clause table length.
package uc_pkg;

  localparam int UC_LENGTH = 512;
  localparam int UC_LIT_W  = $clog2(UC_LENGTH);
  localparam int UCQ_DEPTH = 4;

  typedef logic [UC_LIT_W-1:0] lit_t;

  // One extra wrap bit beyond the index distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uc_rd_port.sv
// One reader channel of the broadcast queue: owns its head pointer and
// reports how many literals it still has to consume.
module uc_rd_port
  import uc_pkg::*;
#(
  parameter int DEPTH = UCQ_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int IDX_W = PTR_W - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_en,
  input  logic             i_pop_ready,
  input  logic [PTR_W-1:0] i_tail,
  output logic             o_pop_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic [PTR_W-1:0] o_occ
);

  logic [PTR_W-1:0] r_head;

  assign o_pop_valid = i_en && (r_head != i_tail);
  assign o_idx       = r_head[IDX_W-1:0];
  assign o_occ       = i_tail - r_head;

  // A disabled or flushed reader tracks the tail so it only ever sees newer literals.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
    end else if (i_flush || !i_en) begin
      r_head <= i_tail;
    end else if (o_pop_valid && i_pop_ready) begin
      r_head <= r_head + 1'b1;
    end
  end

  a_occ_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_occ <= PTR_W'(DEPTH));

endmodule

// File: rtl/uc_bcast_queue.sv
// Single-writer, multi-reader broadcast queue for unit-clause literals.
// A slot is reusable only once every enabled reader has consumed it.
module uc_bcast_queue
  import uc_pkg::*;
#(
  parameter int DEPTH   = UCQ_DEPTH,
  parameter int LIT_W   = UC_LIT_W,
  parameter int NUM_ENG = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_ENG-1:0]              eng_en,
  input  logic                            push_valid,
  input  logic [LIT_W-1:0]                push_lit,
  output logic                            push_ready,
  output logic [NUM_ENG-1:0]              pop_valid,
  output logic [NUM_ENG-1:0][LIT_W-1:0]   pop_lit,
  input  logic [NUM_ENG-1:0]              pop_ready,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [LIT_W-1:0]                r_mem [DEPTH];
  logic [PTR_W-1:0]                r_tail;
  logic [NUM_ENG-1:0][IDX_W-1:0]   w_idx;
  logic [NUM_ENG-1:0][PTR_W-1:0]   w_occ;
  logic [PTR_W-1:0]                w_count;
  logic                            w_push_fire;

  assign w_push_fire = push_valid && push_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_fire) begin
      r_mem[r_tail[IDX_W-1:0]] <= push_lit;
      r_tail <= r_tail + 1'b1;
    end
  end

  for (genvar e = 0; e < NUM_ENG; e++) begin : g_rd
    uc_rd_port #(.DEPTH(DEPTH)) u_rd_port (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .i_en        (eng_en[e]),
      .i_pop_ready (pop_ready[e]),
      .i_tail      (r_tail),
      .o_pop_valid (pop_valid[e]),
      .o_idx       (w_idx[e]),
      .o_occ       (w_occ[e])
    );
    assign pop_lit[e] = r_mem[w_idx[e]];
  end

  // Occupancy is governed by the slowest enabled reader.
  always_comb begin
    w_count = '0;
    for (int e = 0; e < NUM_ENG; e++) begin
      if (eng_en[e] && (w_occ[e] > w_count)) w_count = w_occ[e];
    end
  end

  assign count      = w_count;
  assign full       = (w_count == PTR_W'(DEPTH));
  assign empty      = (w_count == '0);
  assign push_ready = !full && !flush;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_push_fire |-> !full);

endmodule

// File: tb/tb_uc_bcast_queue.sv
// Directed self-checking bench for uc_bcast_queue (DEPTH 4, LIT_W 9, NUM_ENG 4).
module tb_uc_bcast_queue;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [3:0]            eng_en;
  logic                  push_valid;
  logic [8:0]            push_lit;
  logic                  push_ready;
  logic [3:0]            pop_valid;
  logic [3:0][8:0]       pop_lit;
  logic [3:0]            pop_ready;
  logic                  full;
  logic                  empty;
  logic [2:0]            count;

  int checks = 0;
  int errors = 0;

  uc_bcast_queue #(.DEPTH(4), .LIT_W(9), .NUM_ENG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .eng_en     (eng_en),
    .push_valid (push_valid),
    .push_lit   (push_lit),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_lit    (pop_lit),
    .pop_ready  (pop_ready),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [8:0] lit, input logic [3:0] pr);
    push_valid = pv;
    push_lit   = lit;
    pop_ready  = pr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [8:0] orderLits [3];

  initial begin
    orderLits[0] = 9'h011;
    orderLits[1] = 9'h022;
    orderLits[2] = 9'h033;

    rst_n = 1'b0; flush = 1'b0; eng_en = 4'hF;
    push_valid = 1'b0; push_lit = '0; pop_ready = '0;
    tick(); tick();
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_push_ready", 32'(push_ready), 32'd1);
    rst_n = 1'b1;

    // Order and broadcast: each engine pops on its own cycle
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, orderLits[k], 4'h0);
      tick();
    end
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("bc_count3", 32'(count), 32'd3);
    checkOutput("bc_pop_valid", 32'(pop_valid), 32'hF);
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < 4; e++) begin
        checkOutput($sformatf("bc_lit_e%0d_k%0d", e, k), 32'(pop_lit[e]), 32'(orderLits[k]));
        applyStimulus(1'b0, 9'h0, 4'(1 << e));
        tick();
      end
    end
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("bc_empty", 32'(empty), 32'd1);

    // Asynchronous reset with three entries queued
    applyStimulus(1'b1, 9'h0D1, 4'h0); tick();
    applyStimulus(1'b1, 9'h0D2, 4'h0); tick();
    applyStimulus(1'b1, 9'h0D3, 4'h0); tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_pop_valid", 32'(pop_valid), 32'h0);
    checkOutput("mid_rst_push_ready", 32'(push_ready), 32'd1);
    checkOutput("mid_rst_full", 32'(full), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fill while engine 0 stalls; engines 1-3 drain as they go
    applyStimulus(1'b1, 9'h041, 4'b1110); tick();
    applyStimulus(1'b1, 9'h042, 4'b1110); tick();
    applyStimulus(1'b1, 9'h043, 4'b1110); tick();
    applyStimulus(1'b1, 9'h044, 4'b1110); tick();
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_push_ready", 32'(push_ready), 32'd0);
    checkOutput("full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 9'h0EE, 4'b1110); tick();
    checkOutput("full_refused_count", 32'(count), 32'd4);
    checkOutput("full_pop_valid", 32'(pop_valid), 32'b0001);

    // Push and pop together while full: push is refused
    applyStimulus(1'b1, 9'h0EE, 4'hF);
    checkOutput("pp_full_push_ready", 32'(push_ready), 32'd0);
    checkOutput("pp_full_lit0", 32'(pop_lit[0]), 32'h041);
    tick();
    checkOutput("pp_full_count", 32'(count), 32'd3);
    checkOutput("pp_full_notfull", 32'(full), 32'd0);
    checkOutput("pp_full_push_ready_after", 32'(push_ready), 32'd1);

    // Fifth push wraps to index 0
    applyStimulus(1'b1, 9'h055, 4'h0); tick();
    checkOutput("wrap_full", 32'(full), 32'd1);
    checkOutput("wrap_valid1", 32'(pop_valid[1]), 32'd1);
    checkOutput("wrap_lit1", 32'(pop_lit[1]), 32'h055);
    applyStimulus(1'b0, 9'h0, 4'b0001);
    checkOutput("drain_lit0_a", 32'(pop_lit[0]), 32'h042);
    tick();
    checkOutput("drain_lit0_b", 32'(pop_lit[0]), 32'h043);
    tick();
    checkOutput("drain_count2", 32'(count), 32'd2);

    // Push and pop together at count 2
    applyStimulus(1'b1, 9'h066, 4'b0001);
    checkOutput("pp2_lit0", 32'(pop_lit[0]), 32'h044);
    tick();
    checkOutput("pp2_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 9'h0, 4'hF);
    checkOutput("pp2_lit0_wrap", 32'(pop_lit[0]), 32'h055);
    checkOutput("pp2_lit3_wrap", 32'(pop_lit[3]), 32'h055);
    tick();
    checkOutput("pp2_lit2", 32'(pop_lit[2]), 32'h066);
    tick();
    checkOutput("pp2_empty", 32'(empty), 32'd1);

    // Enable mask: backlog on a disabled engine is ignored and discarded
    applyStimulus(1'b1, 9'h071, 4'b1110); tick();
    applyStimulus(1'b1, 9'h072, 4'b1110); tick();
    applyStimulus(1'b1, 9'h073, 4'b1110); tick();
    applyStimulus(1'b1, 9'h074, 4'b1110); tick();
    applyStimulus(1'b0, 9'h0, 4'b1110); tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("en_pre_count", 32'(count), 32'd4);
    checkOutput("en_pre_full", 32'(full), 32'd1);
    eng_en = 4'b1110;
    #1;
    checkOutput("en_mask_count", 32'(count), 32'd0);
    checkOutput("en_mask_full", 32'(full), 32'd0);
    checkOutput("en_mask_empty", 32'(empty), 32'd1);
    checkOutput("en_mask_pop_valid", 32'(pop_valid), 32'h0);
    tick();
    eng_en = 4'hF;
    applyStimulus(1'b1, 9'h0AA, 4'h0);
    checkOutput("reen_no_backlog", 32'(pop_valid), 32'h0);
    tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("reen_pop_valid", 32'(pop_valid), 32'hF);
    checkOutput("reen_lit0", 32'(pop_lit[0]), 32'h0AA);
    checkOutput("reen_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 9'h0, 4'hF); tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("reen_empty", 32'(empty), 32'd1);

    // Flush drops the concurrent push and pops
    applyStimulus(1'b1, 9'h0B1, 4'h0); tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("fl_pre_count", 32'(count), 32'd1);
    flush = 1'b1;
    applyStimulus(1'b1, 9'h0C3, 4'hF);
    checkOutput("fl_push_ready", 32'(push_ready), 32'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("fl_empty", 32'(empty), 32'd1);
    checkOutput("fl_count", 32'(count), 32'd0);
    checkOutput("fl_pop_valid", 32'(pop_valid), 32'h0);
    applyStimulus(1'b1, 9'h1FF, 4'h0); tick();
    applyStimulus(1'b0, 9'h0, 4'h0);
    checkOutput("fl_post_valid", 32'(pop_valid), 32'hF);
    for (int e = 0; e < 4; e++) begin
      checkOutput($sformatf("fl_post_lit_e%0d", e), 32'(pop_lit[e]), 32'h1FF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
